wbi_res_sched: RTL and testbench

- Response-channel scheduler for one daisy-chain node of the wishbone interconnect.
- Shares the single upstream response port (rval/rrdy/lack/err) between NREQ sources, e.g. the local slave node and the downstream daisy-chain stage.
- Grants round-robin and locks the grant for a whole burst until the last-beat (lack) or error handshake, so bursts never interleave.
- A watchdog releases a stalled owner. The parent muxes data/tid using gnt_o.

---
 rtl/wbi_res_sched_pkg.sv | 13 +
 rtl/wbi_rr_pick.sv | 33 +++
 rtl/wbi_res_sched.sv | 146 ++++++++++++++
 tb/tb_wbi_res_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbi_res_sched_pkg.sv
// Shared definitions for the wishbone interconnect response-side schedulers.
package wbi_res_sched_pkg;

  // Scheduler state: no owner, or one owner locked until its burst ends.
  typedef enum logic {
    SCH_IDLE,
    SCH_LOCK
  } sch_state_e;

  // Idle cycles a locked owner may sit silent before the grant is forced away.
  localparam int WBI_TOUT_DEFAULT = 256;

endpackage

// File: rtl/wbi_rr_pick.sv
// Combinational round-robin picker. The search starts one past last_i and
// wraps. An optional masked index is never chosen, which lets a finishing
// owner step aside for every other pending source.
module wbi_rr_pick #(
  parameter int NREQ = 2,
  parameter int GW   = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            mask_en_i,
  input  logic [GW-1:0]   mask_idx_i,
  input  logic [GW-1:0]   last_i,
  output logic [GW-1:0]   win_o,
  output logic            any_o
);

  // Walk sources in priority order and keep the first eligible one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; this prevents latch inference.
    win_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any_o && (j == (int'(last_i) + i) % NREQ) && req_i[j] &&
            !(mask_en_i && (mask_idx_i == GW'(j)))) begin
          // NOTE: blocking assignments here, because later iterations must see the updated any_o.
          any_o = 1'b1;
          win_o = GW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/wbi_res_sched.sv
// Response-channel scheduler for one daisy-chain node. One response source
// at a time owns the upstream port. The grant is locked for a whole burst and
// is released on the last-beat or error handshake. A watchdog can also force
// the release of a silent owner.
module wbi_res_sched
  import wbi_res_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = 3,
  parameter int TOUT = WBI_TOUT_DEFAULT,
  parameter int TW   = 9
) (
  input  logic            mclk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_rval_i,
  input  logic [NREQ-1:0] req_lack_i,
  input  logic [NREQ-1:0] req_err_i,
  input  logic            res_rrdy_i,
  output logic [GW-1:0]   gnt_o,
  output logic            gnt_vld_o,
  output logic [NREQ-1:0] req_rrdy_o,
  output logic            res_rval_o,
  output logic            tout_o,
  output logic [15:0]     beat_cnt_o
);

  sch_state_e      state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   ptr_q, ptr_d;      // next source to get first priority
  logic [TW-1:0]   wd_q, wd_d;
  logic [15:0]     beat_q, beat_d;
  logic            tout_q, tout_d;

  logic [NREQ-1:0] own_oh;
  logic            own_rval;
  logic            own_end;
  logic            locked;
  logic            hs;
  logic            eob;
  logic            wd_expire;
  logic [GW-1:0]   last_owner;
  logic [GW-1:0]   pick_win;
  logic            pick_any;
  logic [GW-1:0]   ptr_after;

  // Decode the registered owner to a one-hot mask so the per-source vectors are never indexed by a variable.
  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      own_oh[i] = (gnt_q == GW'(i));
    end
  end

  assign locked     = (state_q == SCH_LOCK);
  assign own_rval   = |(req_rval_i & own_oh);
  assign own_end    = |((req_lack_i | req_err_i) & own_oh);
  assign hs         = locked & own_rval & res_rrdy_i;
  assign eob        = hs & own_end;
  assign wd_expire  = (TOUT != 0) && locked && !own_rval && (wd_q == TW'(TOUT - 1));
  assign last_owner = (ptr_q == '0) ? GW'(NREQ - 1) : ptr_q - 1'b1;
  assign ptr_after  = (pick_win == GW'(NREQ - 1)) ? '0 : pick_win + 1'b1;

  // The current owner is masked, so on a regrant it is chosen only when no other source requests.
  wbi_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req_i      (req_rval_i),
    .mask_en_i  (locked),
    .mask_idx_i (gnt_q),
    .last_i     (last_owner),
    .win_o      (pick_win),
    .any_o      (pick_any)
  );

  // Next-state logic: grant from IDLE, hold or rotate on end of burst or watchdog expiry, count beats.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    beat_d  = beat_q;
    tout_d  = 1'b0;
    unique case (state_q)
      SCH_IDLE: begin
        if (pick_any) begin
          state_d = SCH_LOCK;
          gnt_d   = pick_win;
          ptr_d   = ptr_after;
          beat_d  = '0;
          wd_d    = '0;
        end
      end
      SCH_LOCK: begin
        if (eob || wd_expire) begin
          tout_d = wd_expire;
          wd_d   = '0;
          beat_d = '0;
          if (pick_any) begin
            gnt_d = pick_win;
            ptr_d = ptr_after;
          end else begin
            state_d = SCH_IDLE;
          end
        end else if (hs) begin
          beat_d = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
          wd_d   = '0;
        end else if (own_rval) begin
          // Upstream backpressure is not owner idleness.
          wd_d = '0;
        end else if (TOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= SCH_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      beat_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all flops, so every register samples the pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      beat_q  <= beat_d;
      tout_q  <= tout_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_vld_o  = locked;
  assign req_rrdy_o = own_oh & {NREQ{locked & res_rrdy_i}};
  assign res_rval_o = locked & own_rval;
  assign tout_o     = tout_q;
  assign beat_cnt_o = beat_q;

endmodule

// File: tb/tb_wbi_res_sched.sv
// Directed bench for wbi_res_sched. Each test pushes the beats and watchdog
// pulses it expects into queues. A monitor pops and compares those entries on
// every upstream handshake and on every tout pulse.
module tb_wbi_res_sched;

  localparam int NREQ = 2;
  localparam int GW   = 3;
  localparam int TOUT = 8;
  localparam int TW   = 9;

  logic            mclk = 1'b0;
  logic            reset;
  logic [NREQ-1:0] req_rval_i, req_lack_i, req_err_i;
  logic            res_rrdy_i;
  logic [GW-1:0]   gnt_o;
  logic            gnt_vld_o;
  logic [NREQ-1:0] req_rrdy_o;
  logic            res_rval_o;
  logic            tout_o;
  logic [15:0]     beat_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mark   = 0;
  int hs_cnt = 0;

  // dly: cycles since the previous handshake or explicit mark; -1 means not checked.
  typedef struct {
    int gnt;
    int cnt;
    int dly;
  } beat_t;

  beat_t exp_q[$];
  int    tout_q[$];

  // Source model state: beats left, beats done, beat number carrying err, beat count after which rval drops.
  int src_rem  [NREQ];
  int src_beat [NREQ];
  int src_errb [NREQ];
  int src_stop [NREQ];
  bit src_hold [NREQ];

  wbi_res_sched #(
    .NREQ (NREQ),
    .GW   (GW),
    .TOUT (TOUT),
    .TW   (TW)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .req_rval_i (req_rval_i),
    .req_lack_i (req_lack_i),
    .req_err_i  (req_err_i),
    .res_rrdy_i (res_rrdy_i),
    .gnt_o      (gnt_o),
    .gnt_vld_o  (gnt_vld_o),
    .req_rrdy_o (req_rrdy_o),
    .res_rval_o (res_rval_o),
    .tout_o     (tout_o),
    .beat_cnt_o (beat_cnt_o)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_rval_i[k] = (src_rem[k] != 0) && !src_hold[k];
      req_lack_i[k] = (src_rem[k] == 1);
      req_err_i[k]  = (src_errb[k] != 0) && (src_errb[k] == src_beat[k] + 1);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #2;
  endtask

  task automatic issue(input int k, input int len, input int errb, input int stop);
    src_rem[k]  = len;
    src_beat[k] = 0;
    src_errb[k] = errb;
    src_stop[k] = stop;
    src_hold[k] = 1'b0;
    drive();
  endtask

  task automatic abort_all();
    for (int k = 0; k < NREQ; k++) begin
      src_rem[k]  = 0;
      src_hold[k] = 1'b0;
    end
    drive();
  endtask

  task automatic exp_beat(input int g, input int c, input int d);
    beat_t b;
    b.gnt = g;
    b.cnt = c;
    b.dly = d;
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || tout_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    check(name, exp_q.size() + tout_q.size(), 0);
  endtask

  // Source model: advance each source on its own handshake, then redrive the inputs.
  initial begin : src_model
    logic [NREQ-1:0] hs_v;
    forever begin
      @(negedge mclk);
      hs_v = req_rval_i & req_rrdy_o;
      @(posedge mclk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (hs_v[k] && !reset) begin
          if (req_err_i[k]) src_rem[k] = 0;
          else              src_rem[k] = src_rem[k] - 1;
          src_beat[k] = src_beat[k] + 1;
          if (src_stop[k] != 0 && src_beat[k] == src_stop[k]) src_hold[k] = 1'b1;
        end
      end
      drive();
    end
  end

  // Monitor: compare each watchdog pulse and each upstream handshake against the queues.
  initial begin : monitor
    beat_t b;
    int    d;
    forever begin
      @(negedge mclk);
      if (tout_o === 1'b1) begin
        if (tout_q.size() == 0) begin
          check("tout_unexpected", tout_q.size(), 1);
        end else begin
          d = tout_q.pop_front();
          check("tout_dly", cyc - mark, d);
        end
      end
      if (res_rval_o === 1'b1 && res_rrdy_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", exp_q.size(), 1);
        end else begin
          b = exp_q.pop_front();
          check("beat_gnt", gnt_o, b.gnt);
          check("beat_cnt", beat_cnt_o, b.cnt);
          check("beat_rrdy", req_rrdy_o, 1 << b.gnt);
          if (b.dly >= 0) check("beat_dly", cyc - mark, b.dly);
        end
        mark   = cyc;
        hs_cnt = hs_cnt + 1;
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish by itself");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int n;
    reset      = 1'b1;
    res_rrdy_i = 1'b1;
    drive();
    repeat (3) step();
    check("rst_gnt", gnt_o, 0);
    check("rst_vld", gnt_vld_o, 0);
    check("rst_tout", tout_o, 0);
    check("rst_beat", beat_cnt_o, 0);
    check("rst_rrdy", req_rrdy_o, 0);
    check("rst_rval", res_rval_o, 0);
    reset = 1'b0;

    // 1: single-beat burst from src0, one-cycle arbitration latency, then back to idle.
    step();
    mark = cyc;
    issue(0, 1, 0, 0);
    exp_beat(0, 0, 1);
    step();
    check("t1_vld", gnt_vld_o, 1);
    check("t1_gnt", gnt_o, 0);
    wait_drain("t1_drain", 10);
    check("t1_idle", gnt_vld_o, 0);

    // 2: src0 4-beat burst, then src1 2-beat burst with no bubble between them.
    mark = cyc;
    issue(0, 4, 0, 0);
    exp_beat(0, 0, 1);
    exp_beat(0, 1, 1);
    exp_beat(0, 2, 1);
    exp_beat(0, 3, 1);
    exp_beat(1, 0, 1);
    exp_beat(1, 1, 1);
    step();
    issue(1, 2, 0, 0);
    wait_drain("t2_drain", 20);
    step();
    check("t2_idle", gnt_vld_o, 0);

    // 3a: owner src1 goes silent; watchdog hands the grant to pending src0.
    mark = cyc;
    issue(1, 3, 0, 1);
    exp_beat(1, 0, 1);
    tout_q.push_back(9);
    repeat (4) step();
    issue(0, 1, 0, 0);
    exp_beat(0, 0, 9);
    wait_drain("t3a_drain", 40);
    step();
    check("t3a_idle", gnt_vld_o, 0);
    // src1 resumes its interrupted burst under a fresh grant.
    mark = cyc;
    src_hold[1] = 1'b0;
    drive();
    exp_beat(1, 0, 1);
    exp_beat(1, 1, 1);
    wait_drain("t3a_resume", 20);
    step();
    check("t3a_resume_idle", gnt_vld_o, 0);

    // 3b: owner src1 goes silent with nobody else pending; watchdog returns to idle.
    mark = cyc;
    issue(1, 2, 0, 1);
    exp_beat(1, 0, 1);
    tout_q.push_back(9);
    wait_drain("t3b_drain", 40);
    check("t3b_idle", gnt_vld_o, 0);
    check("t3b_gnt_hold", gnt_o, 1);
    check("t3b_tout_pulse", tout_o, 0);
    abort_all();

    // 4: 300 cycles of upstream backpressure must not trip the watchdog.
    step();
    res_rrdy_i = 1'b0;
    issue(0, 1, 0, 0);
    exp_beat(0, 0, -1);
    repeat (300) step();
    check("t4_vld", gnt_vld_o, 1);
    check("t4_gnt", gnt_o, 0);
    check("t4_rrdy", req_rrdy_o, 0);
    check("t4_rval", res_rval_o, 1);
    res_rrdy_i = 1'b1;
    wait_drain("t4_drain", 10);
    check("t4_idle", gnt_vld_o, 0);

    // 5: error on beat 2 ends src0's burst early; src1 follows without a bubble.
    mark = cyc;
    issue(0, 4, 2, 0);
    exp_beat(0, 0, 1);
    exp_beat(0, 1, 1);
    exp_beat(1, 0, 1);
    step();
    issue(1, 1, 0, 0);
    wait_drain("t5_drain", 20);
    step();
    check("t5_idle", gnt_vld_o, 0);
    check("t5_src0_done", src_rem[0], 0);

    // 6: asynchronous reset during beat 3 of a src0 burst.
    mark = cyc;
    base = hs_cnt;
    issue(0, 5, 0, 0);
    exp_beat(0, 0, 1);
    exp_beat(0, 1, 1);
    n = 0;
    while (hs_cnt < base + 2 && n < 20) begin
      step();
      n++;
    end
    check("t6_reach_beat3", hs_cnt - base, 2);
    check("t6_pre_beat", beat_cnt_o, 2);
    check("t6_pre_rrdy", req_rrdy_o, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_rst_vld", gnt_vld_o, 0);
    check("t6_rst_rrdy", req_rrdy_o, 0);
    check("t6_rst_beat", beat_cnt_o, 0);
    check("t6_rst_rval", res_rval_o, 0);
    abort_all();
    repeat (2) step();
    reset = 1'b0;
    step();
    // src0 must win again even though it was the last owner before reset.
    mark = cyc;
    issue(0, 1, 0, 0);
    issue(1, 1, 0, 0);
    exp_beat(0, 0, 1);
    exp_beat(1, 0, 1);
    wait_drain("t6_drain", 20);
    step();
    check("t6_idle", gnt_vld_o, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
